vector_alu_seq: RTL and testbench

- Time-multiplexed SIMT vector ALU for the execute stage.
- Accepts one THREADS-wide operation: shared opcode, per-lane operands, per-lane active mask.
- Evaluates lanes PHYS_LANES at a time over several cycles with a small sequencer, and returns a registered result vector plus per-lane and aggregate flags.
- Uses valid/ready handshakes on both sides so the scheduler and writeback can stall it.

---
 rtl/vector_alu_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_vector_alu_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_alu_seq.sv
// Time-multiplexed SIMT vector ALU: one THREADS-wide operation evaluated PHYS_LANES lanes per cycle.
// Optional VALU_SKIP_EN: the sequencer skips lane groups whose mask bits are all zero.
module vector_alu_seq #(
  parameter int THREADS    = 4,
  parameter int WORD_W     = 32,
  parameter int PHYS_LANES = 2
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  op,
  input  logic [THREADS-1:0]          mask,
  input  logic [THREADS*WORD_W-1:0]   porta,
  input  logic [THREADS*WORD_W-1:0]   portb,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [THREADS*WORD_W-1:0]   out,
  output logic [THREADS-1:0]          nf,
  output logic [THREADS-1:0]          zf,
  output logic [THREADS-1:0]          of,
  output logic                        all_zf,
  output logic                        any_nf
);

  localparam int PASSES = THREADS / PHYS_LANES;
  localparam int GRP_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int LANE_W = (THREADS > 1) ? $clog2(THREADS) : 1;
  localparam int SH     = $clog2(WORD_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_SLL  = 4'b0000;
  localparam logic [3:0] OP_SRL  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  typedef struct packed {
    logic [WORD_W-1:0] r;
    logic              ov;
  } lane_res_t;

  function automatic lane_res_t lane_eval(input logic [3:0] f_op,
                                          input logic [WORD_W-1:0] a,
                                          input logic [WORD_W-1:0] b);
    lane_res_t         res;
    logic [WORD_W-1:0] sum;
    logic [WORD_W-1:0] diff;
    res  = '0;
    sum  = a + b;
    diff = a - b;
    case (f_op)
      OP_ADD: begin
        res.r  = sum;
        res.ov = (a[WORD_W-1] == b[WORD_W-1]) && (sum[WORD_W-1] != a[WORD_W-1]);
      end
      OP_SUB: begin
        res.r  = diff;
        res.ov = (a[WORD_W-1] != b[WORD_W-1]) && (diff[WORD_W-1] != a[WORD_W-1]);
      end
      OP_SLL:  res.r = a << b[SH-1:0];
      OP_SRL:  res.r = a >> b[SH-1:0];
      OP_AND:  res.r = a & b;
      OP_OR:   res.r = a | b;
      OP_XOR:  res.r = a ^ b;
      OP_NOR:  res.r = ~(a | b);
      OP_SLT:  res.r = WORD_W'($signed(a) < $signed(b));
      OP_SLTU: res.r = WORD_W'(a < b);
      default: res = '0;
    endcase
    return res;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [GRP_W-1:0]    grp_q, grp_d;
  logic [GRP_W-1:0]    first_grp, next_grp;
  logic                last_grp;
  logic [3:0]          op_q;
  logic [THREADS-1:0]  mask_q;
  logic [WORD_W-1:0]   a_q [THREADS];
  logic [WORD_W-1:0]   b_q [THREADS];
  logic [WORD_W-1:0]   res_q [THREADS];
  logic [WORD_W-1:0]   res_d [THREADS];
  logic [THREADS-1:0]  nf_q, nf_d, zf_q, zf_d, of_q, of_d;
  logic                all_zf_q, all_zf_d, any_nf_q, any_nf_d;
  logic                accept;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;

`ifdef VALU_SKIP_EN
  logic [PASSES-1:0] grp_act_in, grp_act_q;
  for (genvar g = 0; g < PASSES; g++) begin : g_act
    assign grp_act_in[g] = |mask[g*PHYS_LANES +: PHYS_LANES];
    assign grp_act_q[g]  = |mask_q[g*PHYS_LANES +: PHYS_LANES];
  end

  // An all-zero mask still lands on group 0 so the op spends exactly one BUSY cycle.
  always_comb begin
    first_grp = '0;
    next_grp  = grp_q;
    last_grp  = 1'b1;
    for (int g = PASSES - 1; g >= 0; g--) begin
      if (grp_act_in[g]) first_grp = GRP_W'(g);
      if (grp_act_q[g] && (GRP_W'(g) > grp_q)) begin
        next_grp = GRP_W'(g);
        last_grp = 1'b0;
      end
    end
  end
`else
  assign first_grp = '0;
  assign next_grp  = grp_q + 1'b1;
  assign last_grp  = (grp_q == GRP_W'(PASSES - 1));
`endif

  // NOTE: every variable gets its hold value first so no path through the
  // case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    res_d    = res_q;
    nf_d     = nf_q;
    zf_d     = zf_q;
    of_d     = of_q;
    all_zf_d = all_zf_q;
    any_nf_d = any_nf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_BUSY;
          grp_d    = first_grp;
          for (int i = 0; i < THREADS; i++) res_d[i] = '0;
          nf_d     = '0;
          zf_d     = '0;
          of_d     = '0;
          all_zf_d = 1'b1;
          any_nf_d = 1'b0;
        end
      end
      S_BUSY: begin
        for (int p = 0; p < PHYS_LANES; p++) begin
          automatic logic [LANE_W-1:0] lane = LANE_W'(int'(grp_q) * PHYS_LANES + p);
          automatic lane_res_t lr = lane_eval(op_q, a_q[lane], b_q[lane]);
          // Inactive lanes keep the zeros written at acceptance.
          if (mask_q[lane]) begin
            res_d[lane] = lr.r;
            nf_d[lane]  = lr.r[WORD_W-1];
            zf_d[lane]  = (lr.r == '0);
            of_d[lane]  = lr.ov;
            all_zf_d    = all_zf_d & (lr.r == '0);
            any_nf_d    = any_nf_d | lr.r[WORD_W-1];
          end
        end
        if (last_grp) state_d = S_DONE;
        else          grp_d   = next_grp;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      grp_q    <= '0;
      for (int i = 0; i < THREADS; i++) res_q[i] <= '0;
      nf_q     <= '0;
      zf_q     <= '0;
      of_q     <= '0;
      all_zf_q <= 1'b1;
      any_nf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      res_q    <= res_d;
      nf_q     <= nf_d;
      zf_q     <= zf_d;
      of_q     <= of_d;
      all_zf_q <= all_zf_d;
      any_nf_q <= any_nf_d;
    end
  end

  // NOTE: the operand registers are deliberately left without reset; they are
  // only read in BUSY, which is reachable solely through a load.
  always_ff @(posedge CLK) begin
    if (accept) begin
      op_q   <= op;
      mask_q <= mask;
      for (int i = 0; i < THREADS; i++) begin
        a_q[i] <= porta[i*WORD_W +: WORD_W];
        b_q[i] <= portb[i*WORD_W +: WORD_W];
      end
    end
  end

  for (genvar i = 0; i < THREADS; i++) begin : g_pack
    assign out[i*WORD_W +: WORD_W] = res_q[i];
  end

  assign nf     = nf_q;
  assign zf     = zf_q;
  assign of     = of_q;
  assign all_zf = all_zf_q;
  assign any_nf = any_nf_q;

endmodule

// File: tb/tb_vector_alu_seq.sv
// Scoreboard bench for vector_alu_seq: expectations pushed at issue, popped when out_valid rises.
// Latency expectation follows VALU_SKIP_EN when the bench is built with that macro.
module tb_vector_alu_seq;

  localparam int THREADS = 4;
  localparam int WORD_W  = 32;
  localparam int PL      = 2;
  localparam int TW      = THREADS * WORD_W;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      op = '0;
  logic [3:0]      mask = '0;
  logic [TW-1:0]   porta = '0;
  logic [TW-1:0]   portb = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [TW-1:0]   out;
  logic [3:0]      nf, zf, of;
  logic            all_zf, any_nf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [TW-1:0] out;
    logic [3:0]    nf, zf, of;
    logic          all_zf, any_nf;
    int            lat;
  } exp_t;

  exp_t sb[$];

  vector_alu_seq #(.THREADS(THREADS), .WORD_W(WORD_W), .PHYS_LANES(PL)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .mask(mask), .porta(porta), .portb(portb), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .nf(nf), .zf(zf), .of(of),
    .all_zf(all_zf), .any_nf(any_nf)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_lane(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic v);
    logic signed [32:0] s;
    r = 32'd0;
    v = 1'b0;
    s = '0;
    case (o)
      4'b0010: begin s = $signed({a[31], a}) + $signed({b[31], b}); r = s[31:0]; v = s[32] != s[31]; end
      4'b0011: begin s = $signed({a[31], a}) - $signed({b[31], b}); r = s[31:0]; v = s[32] != s[31]; end
      4'b0000: r = a << (b & 32'd31);
      4'b0001: r = a >> (b & 32'd31);
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~(a | b);
      4'b1010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1011: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] m);
    int n;
`ifdef VALU_SKIP_EN
    n = 0;
    if (m[1:0] != 2'b00) n++;
    if (m[3:2] != 2'b00) n++;
    if (n == 0) n = 1;
`else
    n = THREADS / PL;
    if (m == 4'hF) n = THREADS / PL;
`endif
    return n;
  endfunction

  function automatic exp_t model_op(input logic [3:0] o, input logic [3:0] m,
                                    input logic [TW-1:0] a, input logic [TW-1:0] b);
    exp_t e;
    logic [31:0] r;
    logic v;
    e.out = '0; e.nf = '0; e.zf = '0; e.of = '0;
    e.all_zf = 1'b1; e.any_nf = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      model_lane(o, a[i*32 +: 32], b[i*32 +: 32], r, v);
      if (m[i]) begin
        e.out[i*32 +: 32] = r;
        e.nf[i] = r[31];
        e.zf[i] = (r == 32'd0);
        e.of[i] = v;
        if (r != 32'd0) e.all_zf = 1'b0;
        if (r[31]) e.any_nf = 1'b1;
      end
    end
    e.lat = model_lat(m);
    return e;
  endfunction

  task automatic compare_outputs(input string pfx, input exp_t e);
    check({pfx, "_out"}, out, e.out);
    check({pfx, "_nf"}, TW'(nf), TW'(e.nf));
    check({pfx, "_zf"}, TW'(zf), TW'(e.zf));
    check({pfx, "_of"}, TW'(of), TW'(e.of));
    check({pfx, "_all_zf"}, TW'(all_zf), TW'(e.all_zf));
    check({pfx, "_any_nf"}, TW'(any_nf), TW'(e.any_nf));
  endtask

  // Issue one op, scramble the inputs after acceptance, wait for the result,
  // optionally stall the consumer for `hold` cycles, then retire it.
  task automatic run_op(input string pfx, input logic [3:0] o, input logic [3:0] m,
                        input logic [TW-1:0] a, input logic [TW-1:0] b, input int hold);
    exp_t e;
    int waited;
    int lat;
    @(negedge CLK);
    waited = 0;
    while (!in_ready && waited < 20) begin @(negedge CLK); waited++; end
    check({pfx, "_in_ready"}, TW'(in_ready), TW'(1));
    op = o; mask = m; porta = a; portb = b; in_valid = 1'b1;
    sb.push_back(model_op(o, m, a, b));
    @(posedge CLK); #1;
    in_valid = 1'b0;
    op = 4'($urandom); mask = 4'($urandom);
    for (int i = 0; i < THREADS; i++) begin
      porta[i*32 +: 32] = $urandom;
      portb[i*32 +: 32] = $urandom;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge CLK); #1; lat++; end
    e = sb.pop_front();
    check({pfx, "_latency"}, TW'(lat), TW'(e.lat));
    compare_outputs(pfx, e);
    for (int c = 0; c < hold; c++) begin
      @(negedge CLK);
      in_valid = 1'b1;
      @(posedge CLK); #1;
      check({pfx, "_hold_valid"}, TW'(out_valid), TW'(1));
      check({pfx, "_hold_in_ready"}, TW'(in_ready), TW'(0));
      compare_outputs({pfx, "_hold"}, e);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check({pfx, "_retire_valid"}, TW'(out_valid), TW'(0));
    check({pfx, "_retire_in_ready"}, TW'(in_ready), TW'(1));
  endtask

  logic [TW-1:0] a_v, b_v;
  logic [3:0]    ops [10];

  initial begin
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0101, 4'b0110, 4'b0111, 4'b1010, 4'b1011};
    repeat (2) @(posedge CLK);
    #1;
    check("rst_in_ready", TW'(in_ready), TW'(1));
    check("rst_out_valid", TW'(out_valid), TW'(0));
    check("rst_out", out, '0);
    check("rst_flags", TW'({nf, zf, of, any_nf}), '0);
    check("rst_all_zf", TW'(all_zf), TW'(1));
    @(negedge CLK);
    nRST = 1'b1;

    // ADD with a signed overflow in lane 2 and a zero sum in lane 1.
    run_op("add", 4'b0010, 4'b1111,
           {32'd1, 32'h7FFFFFFF, 32'd5, 32'd0}, {32'd2, 32'd1, 32'hFFFFFFFB, 32'd0}, 0);
    // Direct read-back of the first op's registers, which stay after retirement.
    check("add_out_const", out, {32'd3, 32'h80000000, 32'd0, 32'd0});
    check("add_of_const", TW'(of), TW'(4'b0100));

    run_op("sub_mask", 4'b0011, 4'b0101, {4{32'd7}}, {4{32'd7}}, 0);
    run_op("slt", 4'b1010, 4'b1111, {4{32'hFFFFFFFF}}, {4{32'd1}}, 0);
    run_op("sltu", 4'b1011, 4'b1111, {4{32'hFFFFFFFF}}, {4{32'd1}}, 0);
    run_op("sll", 4'b0000, 4'b1111, {4{32'd1}}, {4{32'd35}}, 0);
    run_op("srl_hold", 4'b0001, 4'b1111, {4{32'h80000000}}, {4{32'd33}}, 5);
    run_op("sub_ovf", 4'b0011, 4'b1111,
           {32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd3}, {32'd1, 32'hFFFFFFFF, 32'd1, 32'd5}, 0);
    run_op("undef_op", 4'b1100, 4'b1111, {4{32'hDEADBEEF}}, {4{32'h1}}, 0);
    run_op("mask_zero", 4'b0010, 4'b0000, {4{32'h80000000}}, {4{32'h1}}, 0);
    run_op("mask_lo", 4'b0010, 4'b0011,
           {32'd9, 32'd9, 32'hFFFFFFFF, 32'd4}, {32'd1, 32'd1, 32'd1, 32'd6}, 0);
    run_op("mask_hi", 4'b0110, 4'b1000, {4{32'hF0F0F0F0}}, {4{32'h0FF00FF0}}, 0);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < THREADS; i++) begin
        a_v[i*32 +: 32] = $urandom;
        b_v[i*32 +: 32] = $urandom;
      end
      run_op($sformatf("rnd%0d", k), ops[$urandom_range(9, 0)], 4'($urandom), a_v, b_v, 0);
    end

    // Reset one cycle into BUSY: the in-flight op vanishes immediately.
    @(negedge CLK);
    op = 4'b0010; mask = 4'b1111; porta = {4{32'h80000000}}; portb = {4{32'h80000000}};
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b0;
    #1;
    check("arst_out_valid", TW'(out_valid), TW'(0));
    check("arst_in_ready", TW'(in_ready), TW'(1));
    check("arst_out", out, '0);
    check("arst_all_zf", TW'(all_zf), TW'(1));
    check("arst_any_nf", TW'(any_nf), TW'(0));
    @(negedge CLK);
    nRST = 1'b1;
    run_op("post_rst", 4'b0101, 4'b1111,
           {32'h1, 32'h2, 32'h0, 32'h80000000}, {32'h10, 32'h0, 32'h0, 32'h1}, 0);

    check("sb_empty", TW'(sb.size()), TW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
